// File: rtl/mips_pkg.sv
// Shared definitions for the MEM stage: write-back control bit positions,
// access FSM encoding and the legal range of the memory access latency.
package mips_pkg;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int MEM_LAT_MIN = 1;
    localparam int MEM_LAT_MAX = 15;
    localparam int LAT_CNT_W   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: combinational read, synchronous write.
// Deliberately unreset so contents survive a pipeline reset.
module data_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch resolution, multi-cycle data memory access with
// upstream stall, and the MEM/WB pipeline register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 6,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] write_data,
    input  logic [6:0]        branch_addr,
    input  logic [4:0]        rd,
    input  logic [1:0]        wb,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              branch,
    input  logic              bne,
    input  logic              zf,
    output logic              pc_src,
    output logic [6:0]        branch_target,
    output logic              stall,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] alu_res_o,
    output logic [4:0]        rd_o,
    output logic [1:0]        wb_o
);

    mem_state_t           state, state_n;
    logic [LAT_CNT_W-1:0] cnt, cnt_n;
    logic                 done;
    logic                 mem_op;
    logic [ADDR_W-1:0]    index;
    logic [DATA_W-1:0]    rdata;
    logic                 unused_addr;

    assign pc_src        = (branch & zf) | (bne & ~zf);
    assign branch_target = branch_addr;

    assign mem_op      = mem_read | mem_write;
    assign index       = alu_res[ADDR_W+1:2];
    assign unused_addr = ^{alu_res[DATA_W-1:ADDR_W+2], alu_res[1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // done marks the completion cycle; gated by rst_n so a reset in the middle
    // of an access drops stall at once and discards the pending store.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        done    = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (mem_op) begin
                        if (MEM_LAT > 1) begin
                            stall   = 1'b1;
                            cnt_n   = LAT_CNT_W'(MEM_LAT - 1);
                            state_n = BUSY;
                        end else begin
                            done = 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (cnt > LAT_CNT_W'(1)) begin
                        stall = 1'b1;
                        cnt_n = cnt - LAT_CNT_W'(1);
                    end else begin
                        done    = 1'b1;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    data_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (done & mem_write),
        .addr  (index),
        .wdata (write_data),
        .rdata (rdata)
    );

    // Stall cycles push a bubble; a store (even with mem_read set) returns no data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_o <= '0;
            alu_res_o   <= '0;
            rd_o        <= '0;
            wb_o        <= '0;
        end else if (stall) begin
            read_data_o <= '0;
            alu_res_o   <= '0;
            rd_o        <= '0;
            wb_o        <= '0;
        end else begin
            read_data_o <= (done && mem_read && !mem_write) ? rdata : '0;
            alu_res_o   <= alu_res;
            rd_o        <= rd;
            wb_o        <= wb;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with MEM_LAT = 2: reset, store/load latency,
// branch select, aborted store, address wrap and R-type pass-through.
module tb_mem_stage;
    import mips_pkg::*;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] write_data;
    logic [6:0]        branch_addr;
    logic [4:0]        rd;
    logic [1:0]        wb;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              bne;
    logic              zf;
    logic              pc_src;
    logic [6:0]        branch_target;
    logic              stall;
    logic [DATA_W-1:0] read_data_o;
    logic [DATA_W-1:0] alu_res_o;
    logic [4:0]        rd_o;
    logic [1:0]        wb_o;

    int n_pass = 0;
    int n_tot  = 0;

    mem_stage #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_LAT(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_res       (alu_res),
        .write_data    (write_data),
        .branch_addr   (branch_addr),
        .rd            (rd),
        .wb            (wb),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch        (branch),
        .bne           (bne),
        .zf            (zf),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .stall         (stall),
        .read_data_o   (read_data_o),
        .alu_res_o     (alu_res_o),
        .rd_o          (rd_o),
        .wb_o          (wb_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic nop;
        alu_res = '0; write_data = '0; branch_addr = '0; rd = '0; wb = '0;
        mem_read = 1'b0; mem_write = 1'b0; branch = 1'b0; bne = 1'b0; zf = 1'b0;
    endtask

    // Full two-cycle access; leaves the MEM/WB result of the completion edge visible.
    task automatic access(input logic rd_en, input logic wr_en, input logic [31:0] addr,
                          input logic [31:0] data, input logic [4:0] dst, input logic [1:0] ctl);
        nop();
        mem_read = rd_en; mem_write = wr_en; alu_res = addr; write_data = data;
        rd = dst; wb = ctl;
        tick();
        tick();
        nop();
    endtask

    initial begin
        nop();
        rst_n = 1'b0;
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_rdata", read_data_o, 32'd0);
        chk("rst_alu", alu_res_o, 32'd0);
        chk("rst_rd", 32'(rd_o), 32'd0);
        chk("rst_wb", 32'(wb_o), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // reset asserted during a load stall
        alu_res = 32'h10; mem_read = 1'b1; rd = 5'd5; wb = 2'b11;
        #1 chk("ld_stall_pre", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1 chk("rst_mid_stall", 32'(stall), 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("rst_mid_wb", 32'(wb_o), 32'd0);
        nop();
        rst_n = 1'b1;
        tick();
        chk("rel_rd", 32'(rd_o), 32'd0);
        chk("rel_wb", 32'(wb_o), 32'd0);

        access(1'b0, 1'b1, 32'h10, 32'h1111_1111, 5'd0, 2'b00);

        // store timing: write lands only on the second edge
        alu_res = 32'h10; write_data = 32'hDEAD_BEEF; mem_write = 1'b1;
        #1 chk("st_stall1", 32'(stall), 32'd1);
        tick();
        chk("st_stall2", 32'(stall), 32'd0);
        chk("st_bubble_wb", 32'(wb_o), 32'd0);
        chk("st_not_yet", dut.u_mem.mem[4], 32'h1111_1111);
        tick();
        nop();
        chk("st_commit", dut.u_mem.mem[4], 32'hDEAD_BEEF);

        // load timing
        alu_res = 32'h10; mem_read = 1'b1; rd = 5'd5; wb = 2'b11;
        #1 chk("ld_stall1", 32'(stall), 32'd1);
        tick();
        chk("ld_stall2", 32'(stall), 32'd0);
        chk("ld_bubble_rd", 32'(rd_o), 32'd0);
        chk("ld_bubble_wb", 32'(wb_o), 32'd0);
        tick();
        nop();
        chk("ld_data", read_data_o, 32'hDEAD_BEEF);
        chk("ld_rd", 32'(rd_o), 32'd5);
        chk("ld_wb", 32'(wb_o), 32'b11);
        chk("ld_alu", alu_res_o, 32'h10);

        // branch select, purely combinational
        branch = 1'b1; zf = 1'b1; branch_addr = 7'h2A;
        #1 chk("beq_taken", 32'(pc_src), 32'd1);
        chk("beq_target", 32'(branch_target), 32'h2A);
        chk("beq_nostall", 32'(stall), 32'd0);
        branch = 1'b0; zf = 1'b0;
        #1 chk("beq_clear", 32'(pc_src), 32'd0);
        bne = 1'b1; zf = 1'b1;
        #1 chk("bne_zf1", 32'(pc_src), 32'd0);
        zf = 1'b0;
        #1 chk("bne_zf0", 32'(pc_src), 32'd1);
        nop();
        tick();

        // aborted store leaves earlier value in place
        access(1'b0, 1'b1, 32'h20, 32'h1234_5678, 5'd0, 2'b00);
        alu_res = 32'h20; write_data = 32'hCAFE_F00D; mem_write = 1'b1;
        #1 chk("ab_stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        nop();
        #1 chk("ab_drop", 32'(stall), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        access(1'b1, 1'b0, 32'h20, 32'h0, 5'd7, 2'b11);
        chk("ab_load", read_data_o, 32'h1234_5678);

        // address wrap: 0x100 aliases word 0
        access(1'b0, 1'b1, 32'h100, 32'hA5A5_A5A5, 5'd0, 2'b00);
        access(1'b1, 1'b0, 32'h0, 32'h0, 5'd9, 2'b11);
        chk("wrap_load", read_data_o, 32'hA5A5_A5A5);
        chk("wrap_rd", 32'(rd_o), 32'd9);

        // read and write together behave as a store
        access(1'b1, 1'b1, 32'h30, 32'h0000_0055, 5'd4, 2'b11);
        chk("rw_nodata", read_data_o, 32'd0);
        access(1'b1, 1'b0, 32'h30, 32'h0, 5'd4, 2'b11);
        chk("rw_stored", read_data_o, 32'h0000_0055);

        // R-type pass-through
        alu_res = 32'h7; rd = 5'd3; wb = 2'b10;
        #1 chk("r_nostall", 32'(stall), 32'd0);
        tick();
        chk("r_alu", alu_res_o, 32'h7);
        chk("r_rd", 32'(rd_o), 32'd3);
        chk("r_wb", 32'(wb_o), 32'b10);
        chk("r_regwrite", 32'(wb_o[WB_REGWRITE]), 32'd1);
        chk("r_rdata", read_data_o, 32'd0);
        nop();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, fed directly by the EX/MEM register.
- Resolves branches (PC select and target back to fetch) and performs data-memory loads and stores with a parameterised multi-cycle access latency.
- Stalls upstream while an access is in flight.
- Contains the MEM/WB pipeline register that feeds write-back.

Parameters:
DATA_W, 32, data and ALU result width
ADDR_W, 6, word-address width; memory depth = 2**ADDR_W words
MEM_LAT, 2, cycles per load/store, legal range 1..15

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
alu_res  in  DATA_W  ALU result / byte address from EX/MEM
write_data  in  DATA_W  store data from EX/MEM
branch_addr  in  7  branch target from EX/MEM
rd  in  5  destination register from EX/MEM
wb  in  2  WB controls: bit1 RegWrite, bit0 MemtoReg
mem_read  in  1  load
mem_write  in  1  store
branch  in  1  beq
bne  in  1  bne
zf  in  1  ALU zero flag
pc_src  out  1  take branch
branch_target  out  7  equals branch_addr
stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
read_data_o  out  DATA_W  MEM/WB load data
alu_res_o  out  DATA_W  MEM/WB ALU result
rd_o  out  5  MEM/WB destination
wb_o  out  2  MEM/WB WB controls

Behaviour:
- Reset: asynchronous, active-low; single clock `clk`, asynchronous active-low reset `rst_n`.
- Reset values: read_data_o, alu_res_o, rd_o, wb_o = 0; FSM = IDLE; latency counter = 0; stall = 0.
- Memory array is not cleared by reset; contents are preserved across reset.
- Word index = alu_res[ADDR_W+1:2]. alu_res[1:0] and bits above ADDR_W+1 are ignored, so addresses wrap modulo depth.
- Branch path, combinational, never stalls:
  - pc_src = (branch & zf) | (bne & ~zf)
  - branch_target = branch_addr
- Non-memory op (mem_read = mem_write = 0): stall = 0. Next edge loads MEM/WB with alu_res, rd, wb; read_data_o = 0.
- Memory op: occupies MEM_LAT cycles; upstream holds inputs stable via stall.
  - FSM IDLE: memory op present and MEM_LAT > 1 -> stall = 1, counter = MEM_LAT-1, go BUSY.
  - FSM BUSY: stall = 1 while counter > 1; counter decrements each edge. When counter = 1: stall = 0, go IDLE at next edge.
  - The final (stall = 0) cycle's edge is the completion edge.
  - MEM_LAT = 1: no stall; completes on the first edge.
- Completion edge:
  - Store: writes write_data to the array exactly once.
  - Load: MEM/WB captures read_data_o = mem[index], plus alu_res, rd, wb.
- Stall cycles: MEM/WB loads a bubble (wb_o = 0, rd_o = 0, data = 0) each edge.
- mem_read and mem_write both high: treated as a store; read_data_o = 0.
- Load data reflects all stores completed before the load's completion edge.
- Reset mid-access: FSM to IDLE, counter cleared, stall drops immediately, pending store discarded.
- Branch and memory op together never occur (control guarantees this). Both paths still evaluate independently.

Decomposition:
- Shared package mips_pkg:
  - WB bit indices (WB_REGWRITE = 1, WB_MEMTOREG = 0)
  - FSM state encoding {IDLE, BUSY}
  - MEM_LAT bounds
- One sub-module, data_mem: array of 2**ADDR_W × DATA_W, combinational read, synchronous write on write-enable. No reset.
- FSM, branch logic and MEM/WB register stay in mem_stage.

Test Plan:
1. Reset: rst_n low for 3 cycles during a load stall -> stall = 0 immediately; all outputs 0; rd_o = 0, wb_o = 0 after release.
2. Store, MEM_LAT = 2: alu_res = 0x10, write_data = 0xDEADBEEF, mem_write = 1 -> stall = 1 for exactly 1 cycle; bubble wb_o = 0; write commits on 2nd edge only.
3. Load, MEM_LAT = 2: alu_res = 0x10, mem_read = 1, rd = 5, wb = 2'b11 -> stall 1 cycle, then read_data_o = 0xDEADBEEF, rd_o = 5, wb_o = 2'b11, alu_res_o = 0x10.
4. Branch, no stall:
   - branch = 1, zf = 1, branch_addr = 0x2A -> pc_src = 1 same cycle, branch_target = 0x2A, stall = 0.
   - bne = 1, zf = 1 -> pc_src = 0.
   - bne = 1, zf = 0 -> pc_src = 1.
5. Aborted store: store 0x12345678 to 0x20 completes; then store 0xCAFEF00D to 0x20 with rst_n pulsed during its stall cycle -> later load of 0x20 returns 0x12345678.
6. Wrap and pass-through:
   - Store 0xA5A5A5A5 at alu_res = 0x100; load at 0x0 -> 0xA5A5A5A5.
   - R-type op alu_res = 0x7, rd = 3, wb = 2'b10 -> no stall; next edge alu_res_o = 0x7, rd_o = 3, wb_o = 2'b10, read_data_o = 0.
